// File: rtl/onehot_mon_pkg.sv
// Shared helpers for the one-hot health monitor: legality check, width helpers
// and the first-error capture record.
package onehot_mon_pkg;

  localparam int unsigned MAX_DW  = 64;
  localparam int unsigned MAX_CHW = 8;

  function automatic int unsigned ch_width(input int unsigned n);
    return (n > 1) ? int'($clog2(n)) : 1;
  endfunction

  function automatic int unsigned idx_width(input int unsigned dw);
    return int'($clog2(dw));
  endfunction

  typedef struct packed {
    logic [MAX_CHW-1:0] ch;
    logic [MAX_DW-1:0]  data;
  } cap_rec_t;

  // Callers zero-extend their DW-bit vector; extension does not change one-hotness.
  function automatic logic is_onehot(input logic [MAX_DW-1:0] v, input logic allow_zero);
    if (v == '0) return allow_zero;
    return (v & (v - MAX_DW'(1))) == '0;
  endfunction

endpackage

// File: rtl/onehot_chk.sv
// Single-channel combinational one-hot legality check.
// With ONEHOT_MON_ENC_EN defined, also produces the binary index of the set bit.
module onehot_chk
  import onehot_mon_pkg::*;
#(
  parameter int unsigned DW         = 8,
  parameter bit          ALLOW_ZERO = 1'b0
) (
  input  logic [DW-1:0] vec,
  output logic          legal
`ifdef ONEHOT_MON_ENC_EN
  ,
  output logic [idx_width(DW)-1:0] idx
`endif
);

  always_comb begin
    legal = is_onehot(MAX_DW'(vec), ALLOW_ZERO);
  end

`ifdef ONEHOT_MON_ENC_EN
  localparam int unsigned IW = idx_width(DW);

  // OR of the positions of set bits; only meaningful (and only kept) when strictly one-hot.
  always_comb begin
    idx = '0;
    if (is_onehot(MAX_DW'(vec), 1'b0)) begin
      for (int unsigned i = 0; i < DW; i++) begin
        if (vec[i]) idx = idx | IW'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/onehot_monitor.sv
// Registered multi-channel one-hot monitor with sticky flags, saturating violation
// counter and first-error capture. Optional per-channel index output: ONEHOT_MON_ENC_EN.
module onehot_monitor
  import onehot_mon_pkg::*;
#(
  parameter  int unsigned DW         = 8,
  parameter  int unsigned NCH        = 4,
  parameter  bit          ALLOW_ZERO = 1'b0,
  parameter  int unsigned CNT_W      = 16,
  localparam int unsigned CHW        = ch_width(NCH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              valid_i,
  input  logic [NCH*DW-1:0] data_i,
  input  logic              clr_i,
  output logic              valid_o,
  output logic [NCH-1:0]    onehot_o,
  output logic [NCH-1:0]    err_o,
  output logic [NCH-1:0]    sticky_o,
  output logic [CNT_W-1:0]  viol_cnt_o,
  output logic              first_vld_o,
  output logic [CHW-1:0]    first_ch_o,
  output logic [DW-1:0]     first_data_o
`ifdef ONEHOT_MON_ENC_EN
  ,
  output logic [NCH*idx_width(DW)-1:0] idx_o
`endif
);

  localparam int unsigned SW    = $clog2(NCH + 1);
  localparam int unsigned SUM_W = CNT_W + SW;

  logic [NCH-1:0]   legal;
  logic [NCH-1:0]   viol;
  logic [SW-1:0]    nviol;
  logic [SUM_W-1:0] sum;
  logic [CNT_W-1:0] cnt_next;
  logic             cand_hit;
  cap_rec_t         cand;
  cap_rec_t         cap_q;
  logic             cap_unused;

`ifdef ONEHOT_MON_ENC_EN
  localparam int unsigned IW = idx_width(DW);
  logic [NCH*IW-1:0] idx_w;
`endif

  for (genvar c = 0; c < NCH; c++) begin : g_chk
    onehot_chk #(
      .DW         (DW),
      .ALLOW_ZERO (ALLOW_ZERO)
    ) u_chk (
      .vec   (data_i[c*DW +: DW]),
      .legal (legal[c])
`ifdef ONEHOT_MON_ENC_EN
      ,
      .idx   (idx_w[c*IW +: IW])
`endif
    );
  end

  // Lowest violating channel wins the capture candidate.
  always_comb begin
    viol     = valid_i ? ~legal : '0;
    nviol    = '0;
    cand     = '0;
    cand_hit = 1'b0;
    for (int unsigned c = 0; c < NCH; c++) begin
      if (viol[c]) begin
        nviol = nviol + SW'(1);
        if (!cand_hit) begin
          cand_hit  = 1'b1;
          cand.ch   = MAX_CHW'(c);
          cand.data = MAX_DW'(data_i[c*DW +: DW]);
        end
      end
    end
    sum      = SUM_W'(viol_cnt_o) + SUM_W'(nviol);
    cnt_next = (sum > SUM_W'({CNT_W{1'b1}})) ? '1 : sum[CNT_W-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_o     <= 1'b0;
      onehot_o    <= '0;
      err_o       <= '0;
      sticky_o    <= '0;
      viol_cnt_o  <= '0;
      first_vld_o <= 1'b0;
      cap_q       <= '0;
`ifdef ONEHOT_MON_ENC_EN
      idx_o       <= '0;
`endif
    end else begin
      valid_o  <= valid_i;
      onehot_o <= valid_i ? legal : '0;
      err_o    <= viol;
`ifdef ONEHOT_MON_ENC_EN
      idx_o    <= valid_i ? idx_w : '0;
`endif
      if (clr_i) begin
        sticky_o    <= '0;
        viol_cnt_o  <= '0;
        first_vld_o <= 1'b0;
        cap_q       <= '0;
      end else begin
        sticky_o   <= sticky_o | viol;
        viol_cnt_o <= cnt_next;
        if (!first_vld_o && cand_hit) begin
          first_vld_o <= 1'b1;
          cap_q       <= cand;
        end
      end
    end
  end

  always_comb begin
    first_ch_o   = cap_q.ch[CHW-1:0];
    first_data_o = cap_q.data[DW-1:0];
    cap_unused   = ^cap_q;
  end

endmodule

// File: tb/tb_onehot_monitor.sv
// Self-checking bench for onehot_monitor: three instances (default, ALLOW_ZERO=1,
// CNT_W=2) share stimulus; a popcount-based model feeds a scoreboard queue.
module tb_onehot_monitor;
  import onehot_mon_pkg::*;

  typedef struct packed {
    logic        valid;
    logic [3:0]  onehot;
    logic [3:0]  err;
    logic [3:0]  sticky;
    logic [15:0] cnt;
    logic        fv;
    logic [1:0]  fch;
    logic [7:0]  fd;
  } obs_t;
  typedef obs_t [2:0] obs3_t;

  typedef struct {
    logic        v;
    logic        c;
    logic [31:0] d;
    logic [3:0]  err0;
  } vec_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic        clr   = 1'b0;
  logic [31:0] data  = '0;

  logic        v_o  [3];
  logic [3:0]  oh_o [3];
  logic [3:0]  er_o [3];
  logic [3:0]  st_o [3];
  logic        fv_o [3];
  logic [1:0]  fch_o[3];
  logic [7:0]  fd_o [3];
  logic [15:0] cnt_o0, cnt_oz;
  logic [1:0]  cnt_os;
`ifdef ONEHOT_MON_ENC_EN
  logic [11:0] idx0, idxz, idxs;
`endif

  obs_t  act [3];
  obs3_t exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0]  m_sticky[3];
  int unsigned m_cnt   [3];
  logic        m_fv    [3];
  logic [1:0]  m_fch   [3];
  logic [7:0]  m_fd    [3];
  logic        az      [3] = '{1'b0, 1'b1, 1'b0};
  int unsigned cmax    [3] = '{65535, 65535, 3};
  string       nm      [3] = '{"d0", "dz", "ds"};

  always #5 clk = ~clk;

  onehot_monitor #(.DW(8), .NCH(4), .ALLOW_ZERO(1'b0), .CNT_W(16)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .data_i(data), .clr_i(clr),
    .valid_o(v_o[0]), .onehot_o(oh_o[0]), .err_o(er_o[0]), .sticky_o(st_o[0]),
    .viol_cnt_o(cnt_o0), .first_vld_o(fv_o[0]), .first_ch_o(fch_o[0]), .first_data_o(fd_o[0])
`ifdef ONEHOT_MON_ENC_EN
    , .idx_o(idx0)
`endif
  );

  onehot_monitor #(.DW(8), .NCH(4), .ALLOW_ZERO(1'b1), .CNT_W(16)) dutz (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .data_i(data), .clr_i(clr),
    .valid_o(v_o[1]), .onehot_o(oh_o[1]), .err_o(er_o[1]), .sticky_o(st_o[1]),
    .viol_cnt_o(cnt_oz), .first_vld_o(fv_o[1]), .first_ch_o(fch_o[1]), .first_data_o(fd_o[1])
`ifdef ONEHOT_MON_ENC_EN
    , .idx_o(idxz)
`endif
  );

  onehot_monitor #(.DW(8), .NCH(4), .ALLOW_ZERO(1'b0), .CNT_W(2)) duts (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .data_i(data), .clr_i(clr),
    .valid_o(v_o[2]), .onehot_o(oh_o[2]), .err_o(er_o[2]), .sticky_o(st_o[2]),
    .viol_cnt_o(cnt_os), .first_vld_o(fv_o[2]), .first_ch_o(fch_o[2]), .first_data_o(fd_o[2])
`ifdef ONEHOT_MON_ENC_EN
    , .idx_o(idxs)
`endif
  );

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      act[k].valid  = v_o[k];
      act[k].onehot = oh_o[k];
      act[k].err    = er_o[k];
      act[k].sticky = st_o[k];
      act[k].fv     = fv_o[k];
      act[k].fch    = fch_o[k];
      act[k].fd     = fd_o[k];
      act[k].cnt    = '0;
    end
    act[0].cnt = cnt_o0;
    act[1].cnt = cnt_oz;
    act[2].cnt = {14'd0, cnt_os};
  end

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, a, e, $time);
    end
  endtask

  task automatic cmp(input int k, input obs_t a, input obs_t e);
    chk({nm[k], "_valid_o"},    32'(a.valid),  32'(e.valid));
    chk({nm[k], "_onehot_o"},   32'(a.onehot), 32'(e.onehot));
    chk({nm[k], "_err_o"},      32'(a.err),    32'(e.err));
    chk({nm[k], "_sticky_o"},   32'(a.sticky), 32'(e.sticky));
    chk({nm[k], "_viol_cnt_o"}, 32'(a.cnt),    32'(e.cnt));
    chk({nm[k], "_first_vld"},  32'(a.fv),     32'(e.fv));
    chk({nm[k], "_first_ch"},   32'(a.fch),    32'(e.fch));
    chk({nm[k], "_first_data"}, 32'(a.fd),     32'(e.fd));
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_sticky[k] = '0; m_cnt[k] = 0; m_fv[k] = 1'b0; m_fch[k] = '0; m_fd[k] = '0;
    end
  endtask

  function automatic obs_t model_step(input int k, input logic v, input logic c, input logic [31:0] d);
    obs_t        e;
    int unsigned nv;
    logic [7:0]  ch;
    e  = '0;
    nv = 0;
    e.valid = v;
    for (int i = 0; i < 4; i++) begin
      ch = d[i*8 +: 8];
      if (v) begin
        if ($countones(ch) == 1 || (az[k] && ch == 8'h00)) e.onehot[i] = 1'b1;
        else begin
          e.err[i] = 1'b1;
          nv++;
        end
      end
    end
    if (c) begin
      m_sticky[k] = '0; m_cnt[k] = 0; m_fv[k] = 1'b0; m_fch[k] = '0; m_fd[k] = '0;
    end else begin
      m_sticky[k] = m_sticky[k] | e.err;
      m_cnt[k]    = (m_cnt[k] + nv > cmax[k]) ? cmax[k] : m_cnt[k] + nv;
      if (!m_fv[k] && nv > 0) begin
        for (int i = 3; i >= 0; i--) begin
          if (e.err[i]) begin
            m_fch[k] = 2'(i);
            m_fd[k]  = d[i*8 +: 8];
          end
        end
        m_fv[k] = 1'b1;
      end
    end
    e.sticky = m_sticky[k];
    e.cnt    = 16'(m_cnt[k]);
    e.fv     = m_fv[k];
    e.fch    = m_fch[k];
    e.fd     = m_fd[k];
    return e;
  endfunction

  task automatic step(input logic v, input logic c, input logic [31:0] d);
    obs3_t e;
    @(negedge clk);
    valid = v; clr = c; data = d;
    for (int k = 0; k < 3; k++) e[k] = model_step(k, v, c, d);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      for (int k = 0; k < 3; k++) cmp(k, act[k], e[k]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[9];
    tbl[0] = '{1'b1, 1'b0, 32'h8001_1004, 4'b0000};
    tbl[1] = '{1'b1, 1'b0, 32'h0003_2040, 4'b1100};
    tbl[2] = '{1'b1, 1'b0, 32'h8001_10FF, 4'b0001};
    tbl[3] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 4'b0000};
    tbl[4] = '{1'b1, 1'b0, 32'h0303_0101, 4'b1100};
    tbl[5] = '{1'b1, 1'b0, 32'h0303_0101, 4'b1100};
    tbl[6] = '{1'b1, 1'b0, 32'h0303_0101, 4'b1100};
    tbl[7] = '{1'b1, 1'b1, 32'h0303_0101, 4'b1100};
    tbl[8] = '{1'b1, 1'b0, 32'h0102_0408, 4'b0000};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) cmp(k, act[k], '0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      step(tbl[i].v, tbl[i].c, tbl[i].d);
      chk("tbl_err0", 32'(act[0].err), 32'(tbl[i].err0));
      if (i == 1) begin
        chk("first_ch_d0", 32'(act[0].fch), 32'd2);
        chk("first_data_d0", 32'(act[0].fd), 32'h03);
        chk("err_dz", 32'(act[1].err), 32'b0100);
      end
      if (i == 6) chk("sat_ds", 32'(act[2].cnt), 32'd3);
      if (i == 7) chk("clr_cnt_d0", 32'(act[0].cnt), 32'd0);
    end

    // All-zero sample drives every channel of the default instance into error.
    step(1'b1, 1'b0, 32'h0000_0000);
    chk("pre_rst_sticky", 32'(act[0].sticky), 32'hF);
    #3;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) cmp(k, act[k], '0);
`ifdef ONEHOT_MON_ENC_EN
    chk("rst_idx0", 32'(idx0), 32'd0);
`endif
    model_reset();
    exp_q.delete();
    @(negedge clk);
    valid = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("post_rst_valid_o", 32'(act[0].valid), 32'd0);
    end

`ifdef ONEHOT_MON_ENC_EN
    step(1'b1, 1'b0, 32'h0104_2001);
    chk("idx_ch1_20", 32'(idx0[3 +: 3]), 32'd5);
    step(1'b1, 1'b0, 32'h0104_2101);
    chk("idx_ch1_21", 32'(idx0[3 +: 3]), 32'd0);
    chk("err_ch1_21", 32'(act[0].err[1]), 32'd1);
`endif

    step(1'b0, 1'b0, 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
